// File: rtl/hyperbus_trans_arbiter_if.sv
// hyperbus_trans_arbiter_if: requester trans channels, PHY trans channel, completion monitors and owner status
interface hyperbus_trans_arbiter_if #(
  parameter int NR_REQ      = 2,
  parameter int NR_CS       = 2,
  parameter int BURST_WIDTH = 12
);
  localparam int IDX_W = $clog2(NR_REQ);
  logic [NR_REQ-1:0]             req_valid;
  logic [NR_REQ-1:0]             req_ready;
  logic [NR_REQ*32-1:0]          req_address;
  logic [NR_REQ*NR_CS-1:0]       req_cs;
  logic [NR_REQ-1:0]             req_write;
  logic [NR_REQ*BURST_WIDTH-1:0] req_burst;
  logic [NR_REQ-1:0]             req_burst_type;
  logic [NR_REQ-1:0]             req_address_space;
  logic                          trans_valid;
  logic                          trans_ready;
  logic [31:0]                   trans_address;
  logic [NR_CS-1:0]              trans_cs;
  logic                          trans_write;
  logic [BURST_WIDTH-1:0]        trans_burst;
  logic                          trans_burst_type;
  logic                          trans_address_space;
  logic                          rx_valid;
  logic                          rx_ready;
  logic                          rx_last;
  logic                          b_valid;
  logic [IDX_W-1:0]              owner;
  logic                          owner_valid;
  logic                          timeout;
  modport master (
    output req_valid, req_address, req_cs, req_write, req_burst, req_burst_type, req_address_space,
    output trans_ready, rx_valid, rx_ready, rx_last, b_valid,
    input  req_ready, trans_valid, trans_address, trans_cs, trans_write, trans_burst,
    input  trans_burst_type, trans_address_space, owner, owner_valid, timeout
  );
  modport slave (
    input  req_valid, req_address, req_cs, req_write, req_burst, req_burst_type, req_address_space,
    input  trans_ready, rx_valid, rx_ready, rx_last, b_valid,
    output req_ready, trans_valid, trans_address, trans_cs, trans_write, trans_burst,
    output trans_burst_type, trans_address_space, owner, owner_valid, timeout
  );
endinterface

// File: rtl/hyperbus_trans_arbiter.sv
// hyperbus_trans_arbiter: round-robin owner of the HyperBus trans channel, held until completion (watchdog: HYPERBUS_ARB_TIMEOUT_EN)
module hyperbus_trans_arbiter #(
  parameter int NR_REQ      = 2,
  parameter int NR_CS       = 2,
  parameter int BURST_WIDTH = 12,
  parameter int TIMEOUT     = 4096
) (
  input logic clk_i,
  input logic rst_i,
  hyperbus_trans_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NR_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t           state;
  logic [IDX_W-1:0] rr_ptr, owner, grant, cand, owner_nxt;
  logic             write_q, trans_valid_q, owner_valid_q, iss, done;
  if (NR_REQ < 2 || TIMEOUT < 2) begin : g_cfg_check
    $error("hyperbus_trans_arbiter: NR_REQ and TIMEOUT must be >= 2");
  end
  // Scan downward so the candidate closest to rr_ptr is the one that sticks.
  always_comb begin
    grant = rr_ptr;
    cand  = rr_ptr;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NR_REQ);
      if (bus.req_valid[cand]) grant = cand;
    end
  end
  assign owner_nxt = (owner == IDX_W'(NR_REQ - 1)) ? '0 : owner + IDX_W'(1);
  assign iss       = state == ISSUE;
  assign done      = write_q ? bus.b_valid : (bus.rx_valid & bus.rx_ready & bus.rx_last);
  assign bus.req_ready   = (iss && bus.trans_ready) ? (NR_REQ'(1) << owner) : '0;
  assign bus.trans_valid = trans_valid_q;
  assign bus.owner       = owner;
  assign bus.owner_valid = owner_valid_q;
  always_comb begin
    bus.trans_address       = '0;
    bus.trans_cs            = '0;
    bus.trans_write         = 1'b0;
    bus.trans_burst         = '0;
    bus.trans_burst_type    = 1'b0;
    bus.trans_address_space = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (iss && owner == IDX_W'(k)) begin
        bus.trans_address       = bus.req_address[k*32 +: 32];
        bus.trans_cs            = bus.req_cs[k*NR_CS +: NR_CS];
        bus.trans_write         = bus.req_write[k];
        bus.trans_burst         = bus.req_burst[k*BURST_WIDTH +: BURST_WIDTH];
        bus.trans_burst_type    = bus.req_burst_type[k];
        bus.trans_address_space = bus.req_address_space[k];
      end
    end
  end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wdog;
  logic            timeout_q, expired;
  assign expired     = wdog == WD_W'(TIMEOUT - 1);
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      write_q       <= 1'b0;
      trans_valid_q <= 1'b0;
      owner_valid_q <= 1'b0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      wdog          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: if (|bus.req_valid) begin
          owner         <= grant;
          write_q       <= bus.req_write[grant];
          trans_valid_q <= 1'b1;
          owner_valid_q <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: if (bus.trans_ready) begin
          rr_ptr        <= owner_nxt;
          trans_valid_q <= 1'b0;
          state         <= BUSY;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
          wdog          <= '0;
`endif
        end
        BUSY: if (done) begin
          owner_valid_q <= 1'b0;
          state         <= IDLE;
        end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
        else if (expired) begin
          owner_valid_q <= 1'b0;
          timeout_q     <= 1'b1;
          state         <= IDLE;
        end else begin
          wdog <= wdog + WD_W'(1);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
  // A requester must keep its valid asserted for as long as it owns the ISSUE phase.
  a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i) (state == ISSUE) |-> bus.req_valid[owner]);
endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// tb_hyperbus_trans_arbiter: randomized requester traffic against a transaction-level round-robin model
module tb_hyperbus_trans_arbiter;
  localparam int N = 3, CS = 2, BW = 12, TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hyperbus_trans_arbiter_if #(.NR_REQ(N), .NR_CS(CS), .BURST_WIDTH(BW)) bus ();
  hyperbus_trans_arbiter #(.NR_REQ(N), .NR_CS(CS), .BURST_WIDTH(BW), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  int checks = 0;
  int errors = 0;
  int rr = 0;
  logic [N-1:0]  pend = '0;
  logic [31:0]   m_addr [N];
  logic [CS-1:0] m_cs [N];
  logic          m_wr [N];
  logic [BW-1:0] m_burst [N];
  logic          m_bt [N];
  logic          m_as [N];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic drive_bus();
    for (int k = 0; k < N; k++) begin
      bus.req_address[k*32 +: 32]   = m_addr[k];
      bus.req_cs[k*CS +: CS]        = m_cs[k];
      bus.req_write[k]              = m_wr[k];
      bus.req_burst[k*BW +: BW]     = m_burst[k];
      bus.req_burst_type[k]         = m_bt[k];
      bus.req_address_space[k]      = m_as[k];
    end
    bus.req_valid = pend;
  endtask
  task automatic raise(input logic [N-1:0] add);
    for (int k = 0; k < N; k++) begin
      if (add[k] && !pend[k]) begin
        m_addr[k]  = $urandom;
        m_cs[k]    = CS'($urandom);
        m_wr[k]    = 1'($urandom_range(0, 1));
        m_burst[k] = BW'($urandom_range(1, 4));
        m_bt[k]    = 1'($urandom_range(0, 1));
        m_as[k]    = 1'($urandom_range(0, 1));
      end
    end
    pend = pend | add;
    drive_bus();
  endtask
  task automatic check_issue(input int e);
    check("issue_valid", bus.trans_valid, 1);
    check("issue_owner_valid", bus.owner_valid, 1);
    check("issue_owner", bus.owner, e);
    check("issue_addr", bus.trans_address, m_addr[e]);
    check("issue_cs", bus.trans_cs, m_cs[e]);
    check("issue_write", bus.trans_write, m_wr[e]);
    check("issue_burst", bus.trans_burst, m_burst[e]);
    check("issue_btype", bus.trans_burst_type, m_bt[e]);
    check("issue_aspace", bus.trans_address_space, m_as[e]);
    check("issue_ready_low", bus.req_ready, 0);
    check("issue_timeout_low", bus.timeout, 0);
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_valid"}, bus.trans_valid, 0);
    check({tag, "_owner_valid"}, bus.owner_valid, 0);
    check({tag, "_ready"}, bus.req_ready, 0);
    check({tag, "_addr"}, bus.trans_address, 0);
  endtask
  // mode 0: normal completion, 1: reset two cycles into BUSY, 2: watchdog expiry
  task automatic do_txn(input logic [N-1:0] add, input int mode);
    int e;
    int beats;
    logic [N-1:0] a;
    logic spur;
    a = add;
    if ((pend | a) == '0) a[0] = 1'b1;
    raise(a);
    e = pick(pend, rr);
    step();
    repeat ($urandom_range(0, 3)) begin
      check_issue(e);
      spur = 1'($urandom_range(0, 1));
      bus.b_valid = spur; bus.rx_valid = spur; bus.rx_ready = spur; bus.rx_last = spur;
      step();
      bus.b_valid = 0; bus.rx_valid = 0; bus.rx_ready = 0; bus.rx_last = 0;
    end
    check_issue(e);
    bus.trans_ready = 1'b1;
    #1;
    check("grant_ready", bus.req_ready, N'(1) << e);
    step();
    bus.trans_ready = 1'b0;
    pend[e] = 1'b0;
    drive_bus();
    rr = (e + 1) % N;
    check("busy_valid", bus.trans_valid, 0);
    check("busy_owner_valid", bus.owner_valid, 1);
    check("busy_owner", bus.owner, e);
    check("busy_addr", bus.trans_address, 0);
    if (mode == 1) begin
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      rr = 0;
      check_idle("rst");
      check("rst_owner", bus.owner, 0);
      check("rst_timeout", bus.timeout, 0);
      return;
    end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
    if (mode == 2) begin
      for (int i = 1; i < TO; i++) begin
        step();
        check("wdog_quiet", bus.timeout, 0);
        check("wdog_owner_valid", bus.owner_valid, 1);
      end
      step();
      check("wdog_pulse", bus.timeout, 1);
      check_idle("wdog");
      return;
    end
`else
    if (mode == 2) begin
      repeat (40) step();
      check("no_wdog_timeout", bus.timeout, 0);
      check("no_wdog_owner_valid", bus.owner_valid, 1);
    end
`endif
    if (m_wr[e]) begin
      repeat ($urandom_range(0, 3)) begin
        spur = 1'($urandom_range(0, 1));
        bus.rx_valid = spur; bus.rx_ready = spur; bus.rx_last = spur;
        step();
        check("wr_wait", bus.owner_valid, 1);
      end
      bus.rx_valid = 0; bus.rx_ready = 0; bus.rx_last = 0;
      bus.b_valid = 1'b1;
      step();
      bus.b_valid = 1'b0;
    end else begin
      beats = int'(m_burst[e]);
      for (int b = 0; b < beats; b++) begin
        bus.rx_valid = 1'b1;
        bus.rx_last  = (b == beats - 1);
        bus.b_valid  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          bus.rx_ready = 1'b0;
          step();
          check("rd_stalled", bus.owner_valid, 1);
        end
        bus.rx_ready = 1'b1;
        step();
        if (b != beats - 1) check("rd_beat", bus.owner_valid, 1);
      end
      bus.rx_valid = 0; bus.rx_ready = 0; bus.rx_last = 0; bus.b_valid = 0;
    end
    check_idle("done");
    check("done_owner", bus.owner, e);
  endtask
  initial begin
    bus.req_valid = '0; bus.req_address = '0; bus.req_cs = '0; bus.req_write = '0;
    bus.req_burst = '0; bus.req_burst_type = '0; bus.req_address_space = '0;
    bus.trans_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_ready = 1'b0; bus.rx_last = 1'b0; bus.b_valid = 1'b0;
    repeat (3) step();
    check_idle("reset");
    check("reset_owner", bus.owner, 0);
    check("reset_timeout", bus.timeout, 0);
    rst = 1'b0;
    do_txn(3'b011, 0);
    do_txn(3'b000, 0);
    do_txn(3'b001, 0);
    do_txn(3'b010, 1);
    for (int i = 0; i < 6; i++) do_txn(3'b111, 0);
    do_txn(N'($urandom_range(1, 7)), 2);
    do_txn(3'b000, 0);
    for (int i = 0; i < 40; i++) do_txn(N'($urandom), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
